// File: rtl/shift_deser_bidir.sv
// shift_deser_bidir
// Serial-in / parallel-out receiver for the bidirectional shift register's
// serial stream. Bits arrive LSB-first or MSB-first (order latched on the
// first bit of each frame). The finished WIDTH-bit word is presented on a
// registered output with a valid/ready handshake. A completed word that
// cannot be delivered is dropped and flagged by a sticky overrun bit.

module shift_deser_bidir #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       dr,
    input  logic                       clr,
    input  logic                       o_ready,
    output logic [WIDTH-1:0]           o,
    output logic                       o_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic                       overrun
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    // Registered state
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_sr;
    logic               r_dr_l;
    logic [WIDTH-1:0]   r_o;
    logic               r_o_valid;
    logic               r_overrun;

    // Next-state / datapath wires
    state_t             w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [WIDTH-1:0]   w_sr_nxt;
    logic               w_dr_l_nxt;
    logic [WIDTH-1:0]   w_o_nxt;
    logic               w_o_valid_nxt;
    logic               w_overrun_nxt;

    logic               w_accept;
    logic               w_dr_eff;
    logic [WIDTH-1:0]   w_sr_shift;
    logic               w_last;
    logic               w_consume;
    logic               w_load;
    logic               w_drop;

    // Decode of the current edge: accepted bit, effective order, shifted word
    always_comb begin
        w_accept   = sin_valid & ~clr;
        // The first bit of a frame uses the live dr; later bits use the latched order
        if (r_state == S_IDLE) begin
            w_dr_eff = dr;
        end else begin
            w_dr_eff = r_dr_l;
        end
        if (w_dr_eff) begin
            w_sr_shift = {r_sr[WIDTH-2:0], sin};
        end else begin
            w_sr_shift = {sin, r_sr[WIDTH-1:1]};
        end
        w_last    = w_accept & (r_cnt == CW'(WIDTH - 1));
        w_consume = r_o_valid & o_ready;
        // A finished word loads if the output slot is empty or freed this edge
        w_load    = w_last & (~r_o_valid | o_ready);
        w_drop    = w_last & r_o_valid & ~o_ready;
    end

    // State register and all output/datapath registers (synchronous active-low reset)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_dr_l    <= 1'b0;
            r_o       <= '0;
            r_o_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sr      <= w_sr_nxt;
            r_dr_l    <= w_dr_l_nxt;
            r_o       <= w_o_nxt;
            r_o_valid <= w_o_valid_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Next-state logic for the frame FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (clr) begin
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    w_state_nxt = S_RECV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RECV: begin
                if (clr) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath next values: counter, shift register, order latch, output word, flags
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_sr_nxt      = r_sr;
        w_dr_l_nxt    = r_dr_l;
        w_o_nxt       = r_o;
        w_o_valid_nxt = r_o_valid;
        w_overrun_nxt = r_overrun;

        // Frame collection; clr aborts and discards any bit on this edge
        if (clr) begin
            w_cnt_nxt     = '0;
            w_sr_nxt      = '0;
            w_overrun_nxt = 1'b0;
        end else if (w_accept) begin
            w_sr_nxt = w_sr_shift;
            if (r_state == S_IDLE) begin
                w_dr_l_nxt = dr;
            end else begin
                w_dr_l_nxt = r_dr_l;
            end
            if (w_last) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
            if (w_drop) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_overrun_nxt = r_overrun;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end

        // Output handshake; a consume still happens alongside clr
        if (w_load) begin
            w_o_nxt       = w_sr_shift;
            w_o_valid_nxt = 1'b1;
        end else if (w_consume) begin
            w_o_valid_nxt = 1'b0;
        end else begin
            w_o_valid_nxt = r_o_valid;
        end
    end

    // Outputs are straight from registers (busy is a decode of the state register)
    always_comb begin
        o       = r_o;
        o_valid = r_o_valid;
        busy    = (r_state == S_RECV);
        bit_cnt = r_cnt;
        overrun = r_overrun;
    end

endmodule

// File: tb/tb_shift_deser_bidir.sv
// Directed self-checking bench for shift_deser_bidir (WIDTH = 8).

module tb_shift_deser_bidir;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             sin;
    logic             sin_valid;
    logic             dr;
    logic             clr;
    logic             o_ready;
    logic [WIDTH-1:0] o;
    logic             o_valid;
    logic             busy;
    logic [2:0]       bit_cnt;
    logic             overrun;

    int n_chk;
    int n_err;

    shift_deser_bidir #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .dr        (dr),
        .clr       (clr),
        .o_ready   (o_ready),
        .o         (o),
        .o_valid   (o_valid),
        .busy      (busy),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle to #1 after it
    task automatic step(input logic v, input logic s, input logic d,
                        input logic c, input logic r);
        sin_valid = v;
        sin       = s;
        dr        = d;
        clr       = c;
        o_ready   = r;
        @(posedge clk);
        #1;
    endtask

    // Send a full 8-bit word back-to-back; o_ready only on the last bit
    task automatic send_word(input logic [7:0] w, input logic d, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, d ? w[7-i] : w[i], d, 1'b0, (i == 7) ? rdy_last : 1'b0);
        end
    endtask

    initial begin
        logic [7:0] bits;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; dr = 1'b0; clr = 1'b0; o_ready = 1'b0;
        #2;

        // Reset with a valid bit present
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_o",       32'(o),       32'h00);
        chk("rst_o_valid", 32'(o_valid), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b1;

        // LSB-first, consecutive: bits 0,0,1,1,0,0,1,1 -> 8'b11001100
        bits = 8'b11001100;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[i], 1'b0, 1'b0, 1'b0);
            chk("lsb_bit_cnt", 32'(bit_cnt), (i == 7) ? 32'd0 : 32'(i + 1));
            chk("lsb_busy",    32'(busy),    (i == 7) ? 32'd0 : 32'd1);
        end
        chk("lsb_o",       32'(o),       32'hCC);
        chk("lsb_o_valid", 32'(o_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lsb_consume", 32'(o_valid), 32'h0);

        // MSB-first with gaps, dr dropped to 0 after bit 2 -> 8'b00110011
        bits = 8'b00110011;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[7-i], (i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (i < 7) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                chk("msb_gap_cnt", 32'(bit_cnt), 32'(i + 1));
            end
        end
        chk("msb_o",       32'(o),       32'h33);
        chk("msb_o_valid", 32'(o_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure and overrun
        send_word(8'hA5, 1'b0, 1'b0);
        chk("bp_first_o",   32'(o),       32'hA5);
        chk("bp_first_ovr", 32'(overrun), 32'h0);
        send_word(8'h3C, 1'b0, 1'b0);
        chk("bp_hold_o",    32'(o),       32'hA5);
        chk("bp_hold_vld",  32'(o_valid), 32'h1);
        chk("bp_overrun",   32'(overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_consume",   32'(o_valid), 32'h0);
        chk("bp_ovr_stick", 32'(overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_clr_ovr",   32'(overrun), 32'h0);
        chk("bp_clr_o",     32'(o),       32'hA5);

        // Simultaneous consume and complete
        send_word(8'h11, 1'b0, 1'b0);
        chk("sim_first_o", 32'(o), 32'h11);
        send_word(8'h22, 1'b0, 1'b1);
        chk("sim_o",       32'(o),       32'h22);
        chk("sim_o_valid", 32'(o_valid), 32'h1);
        chk("sim_overrun", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort mid-frame with clr; the bit on the clr edge is discarded
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("abort_cnt3", 32'(bit_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("abort_cnt",  32'(bit_cnt), 32'd0);
        chk("abort_busy", 32'(busy),    32'd0);
        send_word(8'h5A, 1'b0, 1'b0);
        chk("abort_o",     32'(o),       32'h5A);
        chk("abort_o_vld", 32'(o_valid), 32'h1);

        // Create overrun, then partial frame, then reset mid-frame
        send_word(8'hFF, 1'b1, 1'b0);
        chk("pre_rst_ovr", 32'(overrun), 32'h1);
        chk("pre_rst_o",   32'(o),       32'h5A);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("pre_rst_cnt", 32'(bit_cnt), 32'd5);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        chk("rst2_o",       32'(o),       32'h00);
        chk("rst2_o_valid", 32'(o_valid), 32'h0);
        chk("rst2_busy",    32'(busy),    32'h0);
        chk("rst2_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("rst2_overrun", 32'(overrun), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
